// File: rtl/lfsr_7_6_3_1_0_fib.sv
// 7-bit Fibonacci LFSR for x^7 + x^6 + x^3 + x + 1 (maximal length, period 127).
// The state is shifted toward the MSB, and the feedback bit enters at bit 1.
// An all-zero state, which is unreachable in normal use, is steered back to 7'h01
// on the next enabled step.
module lfsr_7_6_3_1_0_fib (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENA,
    output logic [7:1] LFSR_out
);

    logic [7:1] s_q;
    logic [7:1] s_d;
    logic       fb;

    // Next-state: feedback from taps 7, 6, 3, 1; lock-up guard on all-zero; hold when disabled
    always_comb begin
        s_d = s_q;
        fb  = s_q[7] ^ s_q[6] ^ s_q[3] ^ s_q[1];
        if (ENA) begin
            if (s_q == 7'h00) begin
                s_d = 7'h01;
            end else begin
                s_d = {s_q[6:1], fb};
            end
        end
    end

    // State register: synchronous active-low reset has priority over enable
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s_q <= 7'h01;
        end else begin
            s_q <= s_d;
        end
    end

    assign LFSR_out = s_q;

endmodule

// File: tb/tb_lfsr_7_6_3_1_0_fib.sv
// Self-checking bench for lfsr_7_6_3_1_0_fib: directed checks plus randomized
// enable/reset traffic compared against a behavioural model.
module tb_lfsr_7_6_3_1_0_fib;

    logic       CLK;
    logic       RST;
    logic       ENA;
    logic [7:1] LFSR_out;

    int unsigned ntests;
    int unsigned nfail;
    logic [6:0]  model;

    lfsr_7_6_3_1_0_fib dut (
        .CLK      (CLK),
        .RST      (RST),
        .ENA      (ENA),
        .LFSR_out (LFSR_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Next state from the recurrence: shift left, new LSB is the parity of the
    // tapped bits x^7, x^6, x^3, x^1 (mask 7'b110_0101); zero recovers to 1.
    function automatic logic [6:0] model_next(input logic [6:0] st);
        int v;
        int p;
        v = int'(st);
        if (v == 0) return 7'h01;
        p = $countones(v & 'h65) % 2;
        return 7'((v * 2) % 128 + p);
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, update the model, sample 1 unit later
    task automatic step(input logic r, input logic e);
        RST = r;
        ENA = e;
        @(posedge CLK);
        if (!r) model = 7'h01;
        else if (e) model = model_next(model);
        #1;
    endtask

    initial begin
        logic [6:0] init_seq [6];
        bit         seen [128];
        logic [6:0] start;
        int         first_repeat;
        int         distinct;
        bit         saw_zero;

        ntests = 0;
        nfail  = 0;
        model  = 7'h00;
        RST    = 1'b0;
        ENA    = 1'b1;
        init_seq[0] = 7'h03; init_seq[1] = 7'h07; init_seq[2] = 7'h0E;
        init_seq[3] = 7'h1D; init_seq[4] = 7'h3A; init_seq[5] = 7'h75;
        @(negedge CLK);

        // Reset for two edges with ENA high
        step(1'b0, 1'b1);
        check("reset_edge1", LFSR_out, 7'h01);
        step(1'b0, 1'b1);
        check("reset_edge2", LFSR_out, 7'h01);

        // Initial sequence against constants
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            check("init_seq", LFSR_out, init_seq[i]);
        end

        // Period and coverage
        start        = LFSR_out;
        first_repeat = 0;
        distinct     = 0;
        saw_zero     = 1'b0;
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        seen[start] = 1'b1;
        distinct    = 1;
        for (int i = 1; i <= 127; i++) begin
            step(1'b1, 1'b1);
            check("period_model", LFSR_out, model);
            if (LFSR_out == 7'h00) saw_zero = 1'b1;
            if (LFSR_out == start && first_repeat == 0) first_repeat = i;
            if (!seen[LFSR_out]) begin
                seen[LFSR_out] = 1'b1;
                distinct++;
            end
        end
        ntests++;
        assert (first_repeat == 127) else begin
            nfail++;
            $error("FAIL period: observed %0d expected %0d", first_repeat, 127);
        end
        ntests++;
        assert (distinct == 127) else begin
            nfail++;
            $error("FAIL coverage: observed %0d expected %0d", distinct, 127);
        end
        ntests++;
        assert (saw_zero == 1'b0) else begin
            nfail++;
            $error("FAIL no_zero: observed %0d expected %0d", saw_zero, 0);
        end

        // Hold: reach 0E, disable for 5 edges, re-enable
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("hold_reach", LFSR_out, 7'h0E);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            check("hold", LFSR_out, 7'h0E);
        end
        step(1'b1, 1'b1);
        check("hold_resume", LFSR_out, 7'h1D);

        // Reset mid-run
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1);
        check("midrun_model", LFSR_out, model);
        step(1'b0, 1'b1);
        check("midrun_reset", LFSR_out, 7'h01);
        step(1'b1, 1'b1);
        check("midrun_release", LFSR_out, 7'h03);

        // Randomized enable/reset traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)));
            check("random", LFSR_out, model);
        end

        // Lock-up guard: zero holds while disabled, recovers to 01 when enabled
        force dut.s_q = 7'h00;
        #1;
        release dut.s_q;
        model = 7'h00;
        check("zero_forced", LFSR_out, 7'h00);
        step(1'b1, 1'b0);
        check("zero_hold", LFSR_out, 7'h00);
        step(1'b1, 1'b1);
        check("zero_recover", LFSR_out, 7'h01);
        step(1'b1, 1'b1);
        check("zero_after", LFSR_out, 7'h03);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
